// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
//
// Shared definitions for the four-requester round-robin arbiter:
//   NUM_REQ     number of requesters sharing the datapath
//   SEL_W       width of a requester index / mux select
//   arb_state_t lock FSM states (IDLE searches, BURST holds the grant)
//   rr_pick     round-robin search helper returning {found, idx}
// ---------------------------------------------------------------------------
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // Search order is ptr+1, ptr+2, ptr+3, ptr (mod NUM_REQ), so the last
  // granted requester has the lowest priority on the next search.
  // Result: {found, idx}. idx is only meaningful when found is 1.
  function automatic logic [SEL_W:0] rr_pick(
    input logic [SEL_W-1:0]   ptr,
    input logic [NUM_REQ-1:0] valid
  );
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    idx   = ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      // The index arithmetic wraps naturally at SEL_W bits; k = NUM_REQ
      // lands back on ptr itself.
      cand = ptr + SEL_W'(k);
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mux4to1.sv
// ---------------------------------------------------------------------------
// mux4to1
//
// Plain combinational 4:1 word multiplexer.
//   WIDTH  data width
//   i_d0..i_d3  input words
//   i_sel       select (0..3)
//   o_y         selected word
// ---------------------------------------------------------------------------
module mux4to1 #(
  parameter int WIDTH = 48
) (
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  input  logic [WIDTH-1:0] i_d3,
  input  logic [1:0]       i_sel,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0: o_y = i_d0;
      2'd1: o_y = i_d1;
      2'd2: o_y = i_d2;
      2'd3: o_y = i_d3;
      default: o_y = i_d0;
    endcase
  end

endmodule

// File: rtl/mux4to1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4to1_rr_arbiter
//
// Round-robin arbiter sharing one WIDTH-bit datapath between four requesters.
// It drives the select of a mux4to1 and registers the chosen word. Multi-beat
// bursts keep their grant until the beat flagged last.
//
// Handshake rule (both sides): a beat moves on a rising CLK edge where valid
// and ready are both high. Upstream: requester i transfers when
// req_valid[i] & req_ready[i]; req_ready is one-hot-or-zero and depends
// combinationally on out_ready, so requesters must not make req_valid depend
// on req_ready. Downstream: a beat leaves when out_valid & out_ready.
//
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   req_valid[3:0]  per-requester valid
//   req_last[3:0]   per-requester last-beat flag (meaningful with valid)
//   req_data0..3    requester payloads
//   req_ready[3:0]  per-requester ready (one-hot-or-zero)
//   out_valid       output register holds a beat
//   out_data        registered payload
//   out_src         requester index that produced out_data
//   out_last        registered last flag of that beat
//   out_ready       downstream accept
//   dbg_state       lock FSM state (0 = IDLE, 1 = BURST)
//   dbg_ptr         round-robin pointer (last granted requester)
// ---------------------------------------------------------------------------
module mux4to1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 48
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       req_valid,
  input  logic [3:0]       req_last,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  input  logic [WIDTH-1:0] req_data3,
  output logic [3:0]       req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  output logic             out_last,
  input  logic             out_ready,
  output logic             dbg_state,
  output logic [1:0]       dbg_ptr
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [SEL_W-1:0]   r_ptr;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [SEL_W-1:0]   r_out_src;
  logic               r_out_last;

  // -------------------------------------------------------------------------
  // Combinational arbitration
  // -------------------------------------------------------------------------
  logic               w_load_en;
  logic               w_grant_vld;
  logic [SEL_W-1:0]   w_grant_idx;
  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_xfer;
  logic               w_xfer_last;
  logic [WIDTH-1:0]   w_mux_data;

  // The output register can take a new beat when it is empty or when its
  // current beat is leaving in this same cycle (no bubble on drain+load).
  assign w_load_en = ~r_out_valid | out_ready;

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = r_ptr;
    case (r_state)
      ARB_IDLE: begin
        {w_grant_vld, w_grant_idx} = rr_pick(r_ptr, req_valid);
      end
      ARB_BURST: begin
        // Lock holds on the burst owner; other requesters are ignored and
        // a missing beat simply stalls (no timeout).
        w_grant_idx = r_ptr;
        w_grant_vld = req_valid[r_ptr];
      end
      default: begin
        w_grant_vld = 1'b0;
        w_grant_idx = r_ptr;
      end
    endcase
  end

  always_comb begin
    w_req_ready = '0;
    if (w_load_en && w_grant_vld) begin
      w_req_ready = NUM_REQ'(1) << w_grant_idx;
    end
  end

  assign req_ready   = w_req_ready;
  assign w_xfer      = |(req_valid & w_req_ready);
  assign w_xfer_last = req_last[w_grant_idx];

  // -------------------------------------------------------------------------
  // Payload select
  // -------------------------------------------------------------------------
  mux4to1 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .i_d0  (req_data0),
    .i_d1  (req_data1),
    .i_d2  (req_data2),
    .i_d3  (req_data3),
    .i_sel (w_grant_idx),
    .o_y   (w_mux_data)
  );

  // -------------------------------------------------------------------------
  // Lock FSM
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer) begin
      w_state_nxt = w_xfer_last ? ARB_IDLE : ARB_BURST;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pointer resets to the highest index so requester 0 wins the first search.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr <= SEL_W'(NUM_REQ - 1);
    end else if (w_xfer) begin
      r_ptr <= w_grant_idx;
    end
  end

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux_data;
        r_out_src   <= w_grant_idx;
        r_out_last  <= w_xfer_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_last  = r_out_last;
  assign dbg_state = r_state;
  assign dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_mux4to1_rr_arbiter.sv
module tb_mux4to1_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int WIDTH = 48;
  localparam int W     = 2 + 1 + WIDTH;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic CLK;
  logic RST;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // -------------------------------------------------------------------------
  // DUT
  // -------------------------------------------------------------------------
  logic [3:0]       req_valid;
  logic [3:0]       req_last;
  logic [WIDTH-1:0] req_data [4];
  logic [3:0]       req_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_last;
  logic             out_ready;
  logic             dbg_state;
  logic [1:0]       dbg_ptr;

  mux4to1_rr_arbiter #(
    .WIDTH (WIDTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data0 (req_data[0]),
    .req_data1 (req_data[1]),
    .req_data2 (req_data[2]),
    .req_data3 (req_data[3]),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .out_ready (out_ready),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // -------------------------------------------------------------------------
  // Scoreboard / reference model
  // exp_q holds the beat expected in the output register as {src,last,data}.
  // -------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           m_ptr;
  bit           m_locked;
  int           checks;
  int           failures;
  logic [3:0]   exp_ready;

  function automatic logic [WIDTH-1:0] rand48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ptr    = 3;
    m_locked = 1'b0;
  endtask

  // Which requester the rules say gets the grant now, or -1.
  function automatic int model_grant();
    if (m_locked) return req_valid[m_ptr] ? m_ptr : -1;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    g = model_grant();
    if (g < 0) return 4'b0000;
    if (exp_q.size() != 0 && !out_ready) return 4'b0000;
    return 4'b0001 << g;
  endfunction

  // Advance one clock edge, updating the model with what the edge should do.
  task automatic tick();
    int         g;
    logic [3:0] rdy;
    bit         drain;
    g     = model_grant();
    rdy   = model_ready();
    drain = (exp_q.size() != 0) && out_ready;
    @(posedge CLK);
    if (drain) void'(exp_q.pop_front());
    if (rdy != 4'b0000) begin
      exp_q.push_back({2'(g), req_last[g], req_data[g]});
      m_ptr    = g;
      m_locked = !req_last[g];
    end
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Driver helpers
  // -------------------------------------------------------------------------
  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic o_rdy);
    req_valid = v;
    req_last  = l;
    out_ready = o_rdy;
    for (int i = 0; i < 4; i++) req_data[i] = rand48();
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    RST = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0);
    model_reset();
    #2;
    checks++;
    if ({out_valid, out_data, out_src, out_last} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d=%h s=%0d l=%b exp all zero", out_valid, out_data, out_src, out_last);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    checks++;
    if (dbg_ptr !== 2'd3 || dbg_state !== ARB_IDLE) begin
      failures++;
      $display("FAIL reset_state got ptr=%0d st=%b exp ptr=3 st=IDLE", dbg_ptr, dbg_state);
    end
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_rotation();
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 4'b1111, 1'b1);
      #1;
      exp_ready = model_ready();
      checks++;
      if (req_ready !== exp_ready) begin
        failures++;
        $display("FAIL rot_ready i=%0d got=%b exp=%b", i, req_ready, exp_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'(i % 4)) begin
        failures++;
        $display("FAIL rot_src i=%0d got v=%b s=%0d exp v=1 s=%0d", i, out_valid, out_src, i % 4);
      end
      checks++;
      if (exp_q.size() == 0 || {out_src, out_last, out_data} !== exp_q[0]) begin
        failures++;
        $display("FAIL rot_beat i=%0d got=%h", i, {out_src, out_last, out_data});
      end
    end
  endtask

  task automatic test_burst();
    logic [3:0] vs [5] = '{4'b0100, 4'b0111, 4'b0111, 4'b0011, 4'b0011};
    logic [3:0] ls [5] = '{4'b1011, 4'b1011, 4'b1111, 4'b1111, 4'b1111};
    int         src [5] = '{2, 2, 2, 0, 1};
    for (int i = 0; i < 5; i++) begin
      drive(vs[i], ls[i], 1'b1);
      #1;
      exp_ready = model_ready();
      checks++;
      if (req_ready !== exp_ready) begin
        failures++;
        $display("FAIL burst_ready i=%0d got=%b exp=%b", i, req_ready, exp_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'(src[i]) || out_last !== (i >= 2)) begin
        failures++;
        $display("FAIL burst_src i=%0d got v=%b s=%0d l=%b exp s=%0d", i, out_valid, out_src, out_last, src[i]);
      end
      checks++;
      if (exp_q.size() == 0 || {out_src, out_last, out_data} !== exp_q[0]) begin
        failures++;
        $display("FAIL burst_beat i=%0d got=%h", i, {out_src, out_last, out_data});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] d1;
    drive(4'b0001, 4'b1111, 1'b1);
    req_data[0] = 48'hA5A5_0000_1234;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(4'b0010, 4'b1111, 1'b0);
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_ready i=%0d got=%b exp=0000", i, req_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 48'hA5A5_0000_1234 || out_src !== 2'd0) begin
        failures++;
        $display("FAIL bp_hold i=%0d got v=%b d=%h s=%0d exp v=1 d=a5a500001234 s=0", i, out_valid, out_data, out_src);
      end
    end
    drive(4'b0010, 4'b1111, 1'b1);
    d1 = req_data[1];
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_release_ready got=%b exp=0010", req_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== d1) begin
      failures++;
      $display("FAIL bp_reload got v=%b s=%0d d=%h exp v=1 s=1 d=%h", out_valid, out_src, out_data, d1);
    end
  endtask

  task automatic test_lock();
    drive(4'b0010, 4'b1101, 1'b1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(4'b1000, 4'b1111, 1'b1);
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL lock_stall i=%0d got=%b exp=0000", i, req_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL lock_outv i=%0d got=%b exp=0", i, out_valid);
      end
    end
    drive(4'b1010, 4'b1111, 1'b1);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL lock_last_ready got=%b exp=0010", req_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd1 || out_last !== 1'b1) begin
      failures++;
      $display("FAIL lock_last_beat got v=%b s=%0d l=%b exp v=1 s=1 l=1", out_valid, out_src, out_last);
    end
    drive(4'b1010, 4'b1111, 1'b1);
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL lock_next_ready got=%b exp=1000", req_ready);
    end
    tick();
    checks++;
    if (out_src !== 2'd3) begin
      failures++;
      $display("FAIL lock_next_src got=%0d exp=3", out_src);
    end
  endtask

  task automatic test_reset_mid_burst();
    drive(4'b0100, 4'b0000, 1'b1);
    tick();
    drive(4'b0100, 4'b0000, 1'b1);
    tick();
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL rstmid_clear got v=%b d=%h exp v=0 d=0", out_valid, out_data);
    end
    drive(4'b1111, 4'b1111, 1'b1);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_ready got=%b exp=0001", req_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_first got v=%b s=%0d exp v=1 s=0", out_valid, out_src);
    end
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] d3;
    for (int i = 0; i < 6; i++) begin
      drive(4'b1000, 4'b1111, 1'b1);
      d3 = req_data[3];
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
        failures++;
        $display("FAIL single_ready i=%0d got=%b exp=1000", i, req_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== d3 || out_src !== 2'd3) begin
        failures++;
        $display("FAIL single_data i=%0d got v=%b d=%h s=%0d exp d=%h s=3", i, out_valid, out_data, out_src, d3);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] l;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++) l[b] = ($urandom_range(0, 3) != 0);
      drive(4'($urandom_range(0, 15)), l, ($urandom_range(0, 3) != 0));
      #1;
      exp_ready = model_ready();
      checks++;
      if (req_ready !== exp_ready) begin
        failures++;
        $display("FAIL rand_ready i=%0d got=%b exp=%b", i, req_ready, exp_ready);
      end
      tick();
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL rand_valid i=%0d got=%b exp=%0d", i, out_valid, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        checks++;
        if ({out_src, out_last, out_data} !== exp_q[0]) begin
          failures++;
          $display("FAIL rand_beat i=%0d got=%h exp=%h", i, {out_src, out_last, out_data}, exp_q[0]);
        end
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Sequence + report
  // -------------------------------------------------------------------------
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_rotation();
    test_burst();
    test_backpressure();
    test_lock();
    test_reset_mid_burst();
    test_single();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4to1_rr_arbiter.md
# mux4to1_rr_arbiter

Round-robin arbiter that shares one 48-bit datapath between four requesters by driving the select of the existing `mux4to1` and registering the chosen word. Each requester uses a valid/ready handshake, and multi-beat bursts keep their grant until the last beat. The registered output feeds downstream DSP-slice operand logic, which can apply backpressure.

## Interface
- `WIDTH`, 48: data width of every requester and of the output.
- `CLK`  in  1: single clock; all state updates on its rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `req_valid`  in  4: per-requester valid; bit i belongs to requester i.
- `req_last`  in  4: per-requester last-beat flag; sampled only with `req_valid[i]`.
- `req_data0`..`req_data3`  in  WIDTH each: requester payloads.
- `req_ready`  out  4: one-hot-or-zero; a beat from requester i transfers when `req_valid[i] & req_ready[i]`.
- `out_valid`  out  1: output register holds a beat.
- `out_data`  out  WIDTH: registered selected payload.
- `out_src`  out  2: index of the requester that produced `out_data`.
- `out_last`  out  1: registered `req_last` of that beat.
- `out_ready`  in  1: downstream accept; a beat leaves when `out_valid & out_ready`.

## Operation
- `load_en = ~out_valid | out_ready`.
- `req_ready = load_en ? onehot(grant) : 0`. Grant is a combinational function of state, pointer and `req_valid`.
- IDLE state:
  - Grant goes to the first valid requester, searching in order `ptr+1, ptr+2, ptr+3, ptr` (mod 4).
  - With no valid requester, `req_ready = 0`.
- BURST state: grant is locked to `ptr`. Other requesters are ignored even if valid.
- On a transfer from requester g:
  - Load `out_data`, `out_src=g`, `out_last=req_last[g]`.
  - Set `ptr=g`.
  - If `req_last[g]=0`, go to BURST; otherwise go to (or stay in) IDLE.
- BURST with `req_valid[ptr]=0`: stall with `req_ready=0`. The lock is held; there is no timeout.
- `out_valid` next value:
  - 1 if a transfer occurs.
  - else 0 if `out_ready` is high.
  - else unchanged.
- Data path:
  - `sel = grant`, fed to a `mux4to1 #(WIDTH)` instance.
  - The output register loads the mux output only on a transfer.
  - Data and `out_src` hold while `out_valid & ~out_ready`.
- Pointer and state do not change without a transfer. A requester dropping valid mid-IDLE-search has no effect on them.
- Fairness: in IDLE with all four requesters continuously valid and single-beat, grants rotate 0,1,2,3,0,…

## Timing
- Reset values (asynchronous, immediate):
  - `out_valid=0`, `out_data=0`, `out_src=0`, `out_last=0`.
  - `ptr=3`, so requester 0 has first priority.
  - state IDLE.
  - `req_ready` is combinational and therefore 0, since `out_valid=0` and no requests are valid.
- Latency: a beat accepted at edge k appears on `out_data` with `out_valid=1` after edge k.
- Throughput: 1 beat/cycle while `out_ready=1`.
- Simultaneous drain and load: when `out_valid & out_ready` and a new transfer occur in the same cycle, the register reloads and `out_valid` stays 1 with no bubble.
- `req_ready` depends combinationally on `out_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- Reset asserted mid-burst: the lock is abandoned. After release, arbitration restarts from requester 0.

## Structure
- Package `mux_arb_pkg` holds:
  - `NUM_REQ=4`, `SEL_W=2`.
  - State enum `arb_state_t {ARB_IDLE, ARB_BURST}`.
  - Function `rr_pick(ptr, valid)` returning `{found, idx}`.
- Sub-module: reuse the existing `mux4to1 #(WIDTH)` for payload selection. Arbitration, lock FSM and output register stay in this module.

## Test plan
1. Reset, then `req_valid=4'b1111`, all `req_last=1`, `out_ready=1` for 8 cycles -> `out_src` sequence 0,1,2,3,0,1,2,3, with `out_valid` continuously 1 from the first post-load cycle.
2. Requester 2 sends 3 beats with `req_last=0,0,1` while requesters 0 and 1 stay valid -> `out_src=2,2,2`, then 0 (search from ptr=2 gives 3,0: requester 0), then 1.
3. `out_ready=0` for 4 cycles with one beat 48'hA5A5_0000_1234 loaded -> `out_data` and `out_src` held, `req_ready=0`. `out_ready=1` -> beat drains and the next request loads in the same cycle.
4. BURST lock with requester 1 dropping valid for 2 cycles while requester 3 is valid -> `req_ready=0` throughout, and requester 3 is not granted until requester 1 sends its last beat.
5. Assert `RST` asynchronously mid-burst -> `out_valid=0` and `out_data=0` immediately. After release with all requesters valid, the first grant goes to requester 0.
6. Single requester 3 valid with `out_ready=1` -> `req_ready=4'b1000` every cycle, and `out_data` tracks `req_data3` with 1-cycle latency.
